// File: rtl/tdm_demux8_pkg.sv
// Shared types and frame geometry for the TDM 1:8 demultiplexer; TDM_DEMUX8_PARITY_EN adds a 9th (parity) slot.
// No logic here; latency and backpressure are defined by the users of these constants.
package tdm_demux8_pkg;
  typedef enum logic {HUNT, LOCK} state_t;
`ifdef TDM_DEMUX8_PARITY_EN
  localparam int NUM_SLOTS  = 9;
  localparam int SLOT_IDX_W = 4;
`else
  localparam int NUM_SLOTS  = 8;
  localparam int SLOT_IDX_W = 3;
`endif
  localparam int MISS_W = 3;
endpackage

// File: rtl/tdm_demux8_if.sv
// Serial-lane-in / parallel-frame-out bundle for tdm_demux8; slot width follows TDM_DEMUX8_PARITY_EN.
// Strobe-qualified input (en), no backpressure on the output side.
interface tdm_demux8_if
  import tdm_demux8_pkg::*;
#(
  parameter int W = 1
);
  logic                  en;
  logic                  frame_sync;
  logic [W-1:0]          din;
  logic [8*W-1:0]        o;
  logic                  frame_valid;
  logic [SLOT_IDX_W-1:0] slot;
  logic                  locked;
  logic                  sync_err;
  logic                  par_err;

  modport master (
    output en, frame_sync, din,
    input  o, frame_valid, slot, locked, sync_err, par_err
  );

  modport slave (
    input  en, frame_sync, din,
    output o, frame_valid, slot, locked, sync_err, par_err
  );
endinterface

// File: rtl/tdm_slot_ctr.sv
// Slot position counter (wrap, realign-to-1, clear) plus consecutive missing-sync counter.
// Registered outputs, advances only on commands from the owning FSM; no backpressure.
module tdm_slot_ctr
  import tdm_demux8_pkg::*;
#(
  parameter int MISS_LIMIT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  step,
  input  logic                  load,
  input  logic                  zero,
  input  logic                  miss_inc,
  input  logic                  miss_clr,
  output logic [SLOT_IDX_W-1:0] slot,
  output logic                  at_last,
  output logic                  miss_hit
);
  logic [MISS_W-1:0] miss_cnt;

  assign at_last  = (slot == SLOT_IDX_W'(NUM_SLOTS - 1));
  // High when one more miss would reach the limit.
  assign miss_hit = (miss_cnt == MISS_W'(MISS_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot     <= '0;
      miss_cnt <= '0;
    end else begin
      if (zero)
        slot <= '0;
      else if (load)
        slot <= SLOT_IDX_W'(1);
      else if (step)
        slot <= at_last ? '0 : slot + SLOT_IDX_W'(1);

      if (miss_clr)
        miss_cnt <= '0;
      else if (miss_inc)
        miss_cnt <= miss_cnt + MISS_W'(1);
    end
  end
endmodule

// File: rtl/tdm_demux8.sv
// TDM 1:8 demux with HUNT/LOCK alignment; frame word registered on the last-slot edge (TDM_DEMUX8_PARITY_EN: 9th parity slot).
// One register stage from last slot to o/frame_valid; input paced by en, no output backpressure.
module tdm_demux8
  import tdm_demux8_pkg::*;
#(
  parameter int W          = 1,
  parameter int MISS_LIMIT = 2
) (
  input logic          clk,
  input logic          rst_n,
  tdm_demux8_if.slave  bus
);
  state_t                   state;
  logic [(NUM_SLOTS-1)*W-1:0] shadow;
  logic [8*W-1:0]           o_q;
  logic                     fv_q;
  logic                     se_q;
  logic [SLOT_IDX_W-1:0]    slot;
  logic                     at_last;
  logic                     miss_hit;
  logic                     at_zero, hunt_hit, lock_en, early, miss, drop, step, load;

  assign at_zero  = (slot == '0);
  assign hunt_hit = (state == HUNT) && bus.en && bus.frame_sync;
  assign lock_en  = (state == LOCK) && bus.en;
  assign early    = lock_en && bus.frame_sync && !at_zero;
  assign miss     = lock_en && at_zero && !bus.frame_sync;
  assign drop     = miss && miss_hit;
  assign load     = hunt_hit || early || (lock_en && at_zero && !drop);
  assign step     = lock_en && !at_zero && !bus.frame_sync;

  tdm_slot_ctr #(.MISS_LIMIT(MISS_LIMIT)) u_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (step),
    .load     (load),
    .zero     (drop),
    .miss_inc (miss && !miss_hit),
    .miss_clr (drop || (lock_en && bus.frame_sync)),
    .slot     (slot),
    .at_last  (at_last),
    .miss_hit (miss_hit)
  );

`ifdef TDM_DEMUX8_PARITY_EN
  logic         pe_q;
  logic [W-1:0] par_calc;

  always_comb begin
    par_calc = '0;
    for (int k = 0; k < 8; k++)
      par_calc = par_calc ^ shadow[k*W +: W];
  end
  assign bus.par_err = pe_q;
`else
  assign bus.par_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= HUNT;
      shadow <= '0;
      o_q    <= '0;
      fv_q   <= 1'b0;
      se_q   <= 1'b0;
`ifdef TDM_DEMUX8_PARITY_EN
      pe_q   <= 1'b0;
`endif
    end else begin
      fv_q <= 1'b0;
      se_q <= 1'b0;
`ifdef TDM_DEMUX8_PARITY_EN
      pe_q <= 1'b0;
`endif
      case (state)
        HUNT: begin
          if (hunt_hit) begin
            shadow[0 +: W] <= bus.din;
            state          <= LOCK;
          end
        end
        LOCK: begin
          if (bus.en) begin
            if (early) begin
              // Misplaced sync: drop partial frame, treat this sample as slot 0.
              se_q           <= 1'b1;
              shadow[0 +: W] <= bus.din;
            end else if (at_zero) begin
              se_q <= !bus.frame_sync;
              if (drop)
                state <= HUNT;
              else
                shadow[0 +: W] <= bus.din;
            end else if (at_last) begin
`ifdef TDM_DEMUX8_PARITY_EN
              if (par_calc == bus.din) begin
                o_q  <= shadow;
                fv_q <= 1'b1;
              end else begin
                pe_q <= 1'b1;
              end
`else
              o_q  <= {bus.din, shadow};
              fv_q <= 1'b1;
`endif
            end else begin
              for (int k = 1; k < NUM_SLOTS - 1; k++)
                if (slot == SLOT_IDX_W'(k))
                  shadow[k*W +: W] <= bus.din;
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  assign bus.o           = o_q;
  assign bus.frame_valid = fv_q;
  assign bus.sync_err    = se_q;
  assign bus.slot        = slot;
  assign bus.locked      = (state == LOCK);
endmodule

// File: tb/tb_tdm_demux8.sv
// Randomised + directed scoreboard bench for tdm_demux8 against a queue-based frame model.
module tb_tdm_demux8;
  import tdm_demux8_pkg::*;

  localparam int W  = 1;
  localparam int ML = 2;

  typedef struct {
    logic [SLOT_IDX_W-1:0] slot;
    logic                  locked;
    logic [8*W-1:0]        o;
  } status_t;

  logic clk;
  logic rst_n;

  tdm_demux8_if #(.W(W)) bus ();

  tdm_demux8 #(.W(W), .MISS_LIMIT(ML)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  status_t sq[$];
  int      fvq[$];
  int      seq[$];
  int      peq[$];

  // Reference model: a frame is just the list of samples collected since slot 0.
  bit             m_locked = 0;
  int             m_miss   = 0;
  logic [W-1:0]   mbuf[$];
  logic [8*W-1:0] m_o      = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input bit fs, input logic [W-1:0] d, input int tag);
    logic [8*W-1:0] w;
    logic [W-1:0]   p;
    if (!m_locked) begin
      if (fs) begin
        mbuf.delete();
        mbuf.push_back(d);
        m_locked = 1;
      end
    end else if (fs && mbuf.size() != 0) begin
      seq.push_back(tag);
      mbuf.delete();
      mbuf.push_back(d);
      m_miss = 0;
    end else if (mbuf.size() == 0) begin
      if (fs) m_miss = 0;
      else begin
        seq.push_back(tag);
        m_miss++;
      end
      if (m_miss == ML) begin
        m_locked = 0;
        m_miss   = 0;
      end else begin
        mbuf.push_back(d);
      end
    end else begin
      mbuf.push_back(d);
      if (mbuf.size() == NUM_SLOTS) begin
        w = '0;
        p = '0;
        for (int k = 0; k < 8; k++) begin
          w[k*W +: W] = mbuf[k];
          p = p ^ mbuf[k];
        end
        if (NUM_SLOTS == 8 || mbuf[NUM_SLOTS-1] == p) begin
          m_o = w;
          fvq.push_back(tag);
        end else begin
          peq.push_back(tag);
        end
        mbuf.delete();
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit e, input bit fs, input logic [W-1:0] d);
    status_t st;
    @(negedge clk);
    bus.en         = e;
    bus.frame_sync = fs;
    bus.din        = d;
    if (rst) begin
      rst_n = 1'b0;
      #1;
      chk("rst_o",      bus.o,           0);
      chk("rst_fv",     bus.frame_valid, 0);
      chk("rst_slot",   bus.slot,        0);
      chk("rst_locked", bus.locked,      0);
      chk("rst_se",     bus.sync_err,    0);
      chk("rst_pe",     bus.par_err,     0);
      m_locked = 0;
      m_miss   = 0;
      mbuf.delete();
      m_o = '0;
    end else begin
      rst_n = 1'b1;
      if (e) model_step(fs, d, cyc + 1);
    end
    st.slot   = m_locked ? SLOT_IDX_W'(mbuf.size()) : '0;
    st.locked = m_locked;
    st.o      = m_o;
    sq.push_back(st);
  endtask

  task automatic send_frame(input logic [8*W-1:0] word, input bit fs0, input bit gap, input bit bad_par);
    logic [W-1:0] d;
    logic [W-1:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) p = p ^ word[k*W +: W];
    for (int k = 0; k < NUM_SLOTS; k++) begin
      d = (k < 8) ? word[k*W +: W] : (p ^ W'(bad_par));
      if (gap) cycle(0, 0, 0, '0);
      cycle(0, 1, fs0 && (k == 0), d);
    end
  endtask

  // Monitor: compare DUT state every edge, pop pulse expectations when due.
  initial begin
    status_t st;
    bit      exp_p;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (sq.size() > 0) begin
        st = sq.pop_front();
        chk("slot",   bus.slot,   st.slot);
        chk("locked", bus.locked, st.locked);
        chk("o",      bus.o,      st.o);
        exp_p = (fvq.size() > 0 && fvq[0] == cyc);
        if (exp_p) void'(fvq.pop_front());
        chk("frame_valid", bus.frame_valid, exp_p);
        exp_p = (seq.size() > 0 && seq[0] == cyc);
        if (exp_p) void'(seq.pop_front());
        chk("sync_err", bus.sync_err, exp_p);
        exp_p = (peq.size() > 0 && peq[0] == cyc);
        if (exp_p) void'(peq.pop_front());
        chk("par_err", bus.par_err, exp_p);
      end
    end
  end

  initial begin
    bit           e, fs;
    logic [W-1:0] d;
    rst_n          = 1'b0;
    bus.en         = 1'b0;
    bus.frame_sync = 1'b0;
    bus.din        = '0;
    repeat (3) cycle(1, 0, 0, '0);
    repeat (2) cycle(0, 0, 0, '0);

    // Aligned frame 1,0,1,1,0,0,1,0
    send_frame(8'b01001101, 1, 0, 0);
    cycle(0, 0, 0, '0);
    chk("aligned_o", bus.o, 8'b01001101);
    chk("aligned_locked", bus.locked, 1);

    // Same frame with gapped strobes
    send_frame(8'b01001101, 1, 1, 0);
    cycle(0, 0, 0, '0);
    chk("gapped_o", bus.o, 8'b01001101);

    // Early sync at slot 4 realigns
    cycle(0, 1, 1, 1'b1);
    for (int k = 1; k < 4; k++) cycle(0, 1, 0, W'(k & 1));
    send_frame(8'h3C, 1, 0, 0);
    cycle(0, 0, 0, '0);
    chk("early_o", bus.o, 8'h3C);

    // Missing sync twice with MISS_LIMIT=2
    send_frame(8'h96, 1, 0, 0);
    send_frame(8'h5A, 0, 0, 0);
    cycle(0, 1, 0, 1'b1);
    cycle(0, 0, 0, '0);
    chk("miss_o", bus.o, 8'h5A);
    chk("miss_locked", bus.locked, 0);

    // Async reset at slot 5, then a clean A5 frame
    for (int k = 0; k < 5; k++) cycle(0, 1, k == 0, W'(k & 1));
    repeat (2) cycle(1, 0, 0, '0);
    send_frame(8'hA5, 1, 0, 0);
    cycle(0, 0, 0, '0);
    chk("post_rst_o", bus.o, 8'hA5);

`ifdef TDM_DEMUX8_PARITY_EN
    send_frame(8'h3C, 1, 0, 0);
    send_frame(8'hA5, 1, 0, 1);
    cycle(0, 0, 0, '0);
    chk("bad_par_o", bus.o, 8'h3C);
    chk("bad_par_locked", bus.locked, 1);
    send_frame(8'hA5, 1, 0, 0);
    cycle(0, 0, 0, '0);
    chk("good_par_o", bus.o, 8'hA5);
`endif

    // Random traffic: mostly aligned syncs with occasional missing/misplaced ones
    for (int i = 0; i < 3000; i++) begin
      e = ($urandom_range(0, 3) != 0);
      if (!m_locked || mbuf.size() == 0)
        fs = ($urandom_range(0, 9) != 0);
      else
        fs = ($urandom_range(0, 39) == 0);
      d = W'($urandom);
      cycle(0, e, fs, d);
    end

    repeat (3) cycle(0, 0, 0, '0);
    chk("pending_fv", fvq.size(), 0);
    chk("pending_se", seq.size(), 0);
    chk("pending_pe", peq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
